// File: rtl/pb_varint_stream_decoder.sv
// rtl/pb_varint_stream_decoder.sv - protobuf varint byte-stream decoder (raw, zigzag, key modes)
// One byte per cycle in, one registered result out; overlength varints are drained and flagged.
module pb_varint_stream_decoder #(
  parameter int MAX_BITS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MAX_BITS-1:0] out_value,
  output logic [2:0]          out_wire_type,
  output logic [7:0]          out_nbytes,
  output logic                out_err,
  output logic [15:0]         err_count
);

  localparam int MAX_BYTES = (MAX_BITS + 6) / 7;
  localparam int WW        = MAX_BITS + 7;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t                state_q;
  logic [MAX_BITS-1:0]   acc_q;
  logic                  ovf_q;
  logic [7:0]            cnt_q;
  logic [1:0]            mode_q;
  logic                  out_valid_q;
  logic [MAX_BITS-1:0]   out_value_q;
  logic [2:0]            out_wire_type_q;
  logic [7:0]            out_nbytes_q;
  logic                  out_err_q;
  logic [15:0]           err_count_q;

  logic                  first_byte;
  logic [1:0]            mode_d;
  logic [7:0]            k;
  logic [7:0]            cnt_d;
  logic [10:0]           sh_amt;
  logic [WW-1:0]         shifted;
  logic [MAX_BITS-1:0]   acc_d;
  logic                  ovf_d;
  logic [MAX_BITS-1:0]   value_d;
  logic [2:0]            wire_type_d;
  logic                  bad_wt_d;
  logic                  accept;

  assign in_ready      = !rst && ((state_q != OUT) || out_ready);
  assign accept        = in_valid && in_ready;
  assign out_valid     = out_valid_q;
  assign out_value     = out_value_q;
  assign out_wire_type = out_wire_type_q;
  assign out_nbytes    = out_nbytes_q;
  assign out_err       = out_err_q;
  assign err_count     = err_count_q;

  // A byte taken in IDLE or OUT (the consume cycle) always opens a fresh varint.
  always_comb begin
    first_byte  = (state_q == IDLE) || (state_q == OUT);
    mode_d      = first_byte ? mode : mode_q;
    k           = first_byte ? 8'd0 : cnt_q;
    cnt_d       = (k == 8'hFF) ? 8'hFF : k + 8'd1;
    sh_amt      = 11'(k) * 11'd7;
    shifted     = WW'(in_data[6:0]) << sh_amt;
    acc_d       = (first_byte ? '0 : acc_q) | shifted[MAX_BITS-1:0];
    ovf_d       = (first_byte ? 1'b0 : ovf_q) | (|shifted[WW-1:MAX_BITS]);
    value_d     = acc_d;
    wire_type_d = 3'd0;
    bad_wt_d    = 1'b0;
    case (mode_d)
      2'd1: value_d = (acc_d >> 1) ^ {MAX_BITS{acc_d[0]}};
      2'd2: begin
        value_d     = acc_d >> 3;
        wire_type_d = acc_d[2:0];
        bad_wt_d    = (acc_d[2:1] == 2'b11);
      end
      default: value_d = acc_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      acc_q           <= '0;
      ovf_q           <= 1'b0;
      cnt_q           <= 8'd0;
      mode_q          <= 2'd0;
      out_valid_q     <= 1'b0;
      out_value_q     <= '0;
      out_wire_type_q <= 3'd0;
      out_nbytes_q    <= 8'd0;
      out_err_q       <= 1'b0;
      err_count_q     <= 16'd0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        state_q     <= IDLE;
        if (out_err_q && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 16'd1;
      end
      if (accept) begin
        mode_q <= mode_d;
        cnt_q  <= cnt_d;
        if (state_q == DRAIN) begin
          if (!in_data[7]) begin
            state_q         <= OUT;
            out_valid_q     <= 1'b1;
            out_value_q     <= '0;
            out_wire_type_q <= 3'd0;
            out_nbytes_q    <= cnt_d;
            out_err_q       <= 1'b1;
          end
        end else begin
          acc_q <= acc_d;
          ovf_q <= ovf_d;
          if (!in_data[7]) begin
            state_q         <= OUT;
            out_valid_q     <= 1'b1;
            out_value_q     <= value_d;
            out_wire_type_q <= wire_type_d;
            out_nbytes_q    <= cnt_d;
            out_err_q       <= ovf_d | bad_wt_d;
          end else if (k == 8'(MAX_BYTES - 1)) begin
            state_q <= DRAIN;
          end else begin
            state_q <= ACCUM;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pb_varint_stream_decoder.sv
// tb/tb_pb_varint_stream_decoder.sv - directed scoreboard bench for pb_varint_stream_decoder
module tb_pb_varint_stream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_value;
  logic [2:0]  out_wire_type;
  logic [7:0]  out_nbytes;
  logic        out_err;
  logic [15:0] err_count;

  typedef struct {
    logic [63:0] v;
    logic [2:0]  wt;
    logic [7:0]  nb;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  pb_varint_stream_decoder #(.MAX_BITS(64)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_wire_type(out_wire_type), .out_nbytes(out_nbytes),
    .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic push(input logic [63:0] v, input logic [2:0] wt, input logic [7:0] nb, input logic err);
    exp_t e;
    e.v = v; e.wt = wt; e.nb = nb; e.err = err;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte has been accepted.
  task automatic send(input logic [7:0] b, input logic [1:0] m);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_data = b; mode = m;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {48'd0, out_nbytes, 5'd0, out_wire_type}, 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        chk("out_value", out_value, e.v);
        chk("out_wire_type", 64'(out_wire_type), 64'(e.wt));
        chk("out_nbytes", 64'(out_nbytes), 64'(e.nb));
        chk("out_err", 64'(out_err), 64'(e.err));
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1; mode = 2'd0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    idle(2);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_value", out_value, 64'd0);
    chk("rst_out_nbytes", 64'(out_nbytes), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Raw 150 with an idle gap between the two bytes; result one cycle after 0x01.
    out_ready = 1'b0;
    send(8'h96, 2'd0);
    idle(4);
    chk("gap_no_valid", 64'(out_valid), 64'd0);
    push(64'd150, 3'd0, 8'd2, 1'b0);
    send(8'h01, 2'd0);
    chk("raw_latency", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    idle(2);

    // Zigzag
    push(64'hFFFF_FFFF_FFFF_FFFE, 3'd0, 8'd1, 1'b0);
    send(8'h03, 2'd1);
    push(64'd2, 3'd0, 8'd1, 1'b0);
    send(8'h04, 2'd1);
    idle(2);

    // Key mode, legal then illegal wire type
    push(64'd1, 3'd0, 8'd1, 1'b0);
    send(8'h08, 2'd2);
    push(64'd1, 3'd7, 8'd1, 1'b1);
    send(8'h0F, 2'd2);
    idle(2);
    chk("err_count_key", 64'(err_count), 64'd1);

    // Largest legal 64-bit varint
    for (int i = 0; i < 9; i++) send(8'hFF, 2'd0);
    push(64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 8'd10, 1'b0);
    send(8'h01, 2'd0);
    idle(2);

    // Overlength: 11 x 0xFF then 0x01 goes through DRAIN
    for (int i = 0; i < 11; i++) send(8'hFF, 2'd0);
    push(64'd0, 3'd0, 8'd12, 1'b1);
    send(8'h01, 2'd0);
    idle(2);

    // Overflow on 10th byte
    for (int i = 0; i < 9; i++) send(8'h80, 2'd0);
    push(64'd0, 3'd0, 8'd10, 1'b1);
    send(8'h02, 2'd0);
    idle(2);
    chk("err_count_ovf", 64'(err_count), 64'd3);

    // Backpressure: held result, in_ready low, outputs stable
    out_ready = 1'b0;
    push(64'd5, 3'd0, 8'd1, 1'b0);
    send(8'h05, 2'd0);
    in_valid = 1'b1; in_data = 8'h07;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_value", out_value, 64'd5);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(64'd7, 3'd0, 8'd1, 1'b0);
    send(8'h07, 2'd0);
    base = pop_cyc.size();
    push(64'd1, 3'd0, 8'd1, 1'b0);
    send(8'h01, 2'd0);
    push(64'd2, 3'd0, 8'd1, 1'b0);
    send(8'h02, 2'd0);
    push(64'd3, 3'd0, 8'd1, 1'b0);
    send(8'h03, 2'd0);
    idle(3);
    if (pop_cyc.size() >= base + 3)
      chk("stream_consecutive", 64'(pop_cyc[base+2] - pop_cyc[base]), 64'd2);
    else
      chk("stream_count", 64'(pop_cyc.size() - base), 64'd3);

    // Reset mid-varint
    send(8'h96, 2'd0);
    rst = 1'b1;
    idle(1);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_err_count", 64'(err_count), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
    push(64'd1, 3'd0, 8'd1, 1'b0);
    send(8'h01, 2'd0);
    idle(3);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
